// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Optional starvation guard: DMEM_ARB_STARVE_EN.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 8;
  localparam int WAIT_W       = 8;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_LDR
  } owner_e;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating count of consecutive cycles the loader lost arbitration.
// Used only when DMEM_ARB_STARVE_EN is defined.
module dmem_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [WAIT_W-1:0] LIM = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU / loader arbiter for a single-port synchronous-read data RAM.
// Define DMEM_ARB_STARVE_EN to force a loader grant after MAX_WAIT losses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_valid,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_ready,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_n;
  owner_e     owner, owner_n;
  logic       cpu_gnt, ldr_gnt;
  logic       starve;

`ifdef DMEM_ARB_STARVE_EN
  dmem_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (ldr_valid & ~ldr_gnt),
    .clr  (ldr_gnt | ~ldr_valid),
    .hit  (starve)
  );
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
      owner <= OWN_NONE;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

  // Grants are held low while reset is asserted.
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    state_n = state;
    if (reset) begin
      unique case (state)
        ARB: begin
          if (ldr_valid && (!cpu_req || starve)) begin
            ldr_gnt = 1'b1;
            if (ldr_lock) state_n = LOCK;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end
        end
        LOCK: begin
          ldr_gnt = ldr_valid;
          if (!ldr_lock) state_n = ARB;
        end
        default: state_n = ARB;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_n   = OWN_NONE;
    unique case (1'b1)
      cpu_gnt: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (!cpu_we) owner_n = OWN_CPU;
      end
      ldr_gnt: begin
        mem_en    = 1'b1;
        mem_we    = ldr_we;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        if (!ldr_we) owner_n = OWN_LDR;
      end
      default: ;
    endcase
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign ldr_ready  = ldr_gnt;
  assign cpu_rvalid = (owner == OWN_CPU);
  assign ldr_rvalid = (owner == OWN_LDR);
  assign cpu_rdata  = mem_rdata;
  assign ldr_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural sync-read RAM.
// Contention expectations follow DMEM_ARB_STARVE_EN (MAX_WAIT=3).
module tb_dmem_arbiter;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ldr_valid, ldr_we, ldr_lock, ldr_ready, ldr_rvalid;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram [64];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(3)
  ) dut (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .ldr_valid(ldr_valid), .ldr_we(ldr_we),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_ready(ldr_ready),
    .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  typedef struct {
    logic        creq, cwe;
    logic [7:0]  caddr;
    logic [31:0] cwd;
    logic        lv, lwe, llock;
    logic [7:0]  laddr;
    logic [31:0] lwd;
    logic        stall, ready, en, we;
    logic [7:0]  maddr;
    logic        crv, lrv;
    logic [31:0] rd;
  } vec_t;

  vec_t v [17];

  task automatic drive(input vec_t x);
    cpu_req   = x.creq;
    cpu_we    = x.cwe;
    cpu_addr  = {24'h0, x.caddr};
    cpu_wdata = x.cwd;
    ldr_valid = x.lv;
    ldr_we    = x.lwe;
    ldr_lock  = x.llock;
    ldr_addr  = {24'h0, x.laddr};
    ldr_wdata = x.lwd;
  endtask

  task automatic check(input vec_t x, input string nm);
    logic [37:0] act, exp;
    act = {cpu_stall, ldr_ready, mem_en, mem_we, mem_addr,
           cpu_rvalid, ldr_rvalid};
    exp = {x.stall, x.ready, x.en, x.we, 24'h0, x.maddr,
           x.crv, x.lrv};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s ctl: got %h want %h", nm, act, exp);
    if (x.crv) begin
      total++;
      if (cpu_rdata === x.rd) passed++;
      else $display("FAIL %s cpu_rdata: got %h want %h",
                    nm, cpu_rdata, x.rd);
    end
    if (x.lrv) begin
      total++;
      if (ldr_rdata === x.rd) passed++;
      else $display("FAIL %s ldr_rdata: got %h want %h",
                    nm, ldr_rdata, x.rd);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ldr_wins(input int k);
`ifdef DMEM_ARB_STARVE_EN
    return (k % 4) == 3;
`else
    return (k < 0);
`endif
  endfunction

  initial begin
    vec_t x, idle;
    int   ncont;
    logic prev_c, prev_l, lw;

    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[16] = 32'h1234_5678;
    ram[32] = 32'hCAFE_F00D;
    mem_rdata = 32'h0;

    v[0]  = '{O,O,8'h00,32'h0, O,O,O,8'h00,32'h0,
              O,O,O,O,8'h00,O,O,32'h0};
    v[1]  = '{I,O,8'h40,32'h0, O,O,O,8'h00,32'h0,
              O,O,I,O,8'h40,O,O,32'h0};
    v[2]  = '{O,O,8'h00,32'h0, O,O,O,8'h00,32'h0,
              O,O,O,O,8'h00,I,O,32'h1234_5678};
    v[3]  = '{I,I,8'h44,32'hDEAD_BEEF, O,O,O,8'h00,32'h0,
              O,O,I,I,8'h44,O,O,32'h0};
    v[4]  = '{I,O,8'h80,32'h0, O,O,O,8'h00,32'h0,
              O,O,I,O,8'h80,O,O,32'h0};
    v[5]  = '{O,O,8'h00,32'h0, I,O,O,8'h44,32'h0,
              O,I,I,O,8'h44,I,O,32'hCAFE_F00D};
    v[6]  = '{O,O,8'h00,32'h0, O,O,O,8'h00,32'h0,
              O,O,O,O,8'h00,O,I,32'hDEAD_BEEF};
    v[7]  = '{O,O,8'h00,32'h0, I,I,I,8'h00,32'h1111_1111,
              O,I,I,I,8'h00,O,O,32'h0};
    v[8]  = '{I,O,8'h40,32'h0, I,I,I,8'h04,32'h2222_2222,
              I,I,I,I,8'h04,O,O,32'h0};
    v[9]  = '{I,O,8'h40,32'h0, I,I,O,8'h08,32'h3333_3333,
              I,I,I,I,8'h08,O,O,32'h0};
    v[10] = '{I,O,8'h40,32'h0, O,O,O,8'h00,32'h0,
              O,O,I,O,8'h40,O,O,32'h0};
    v[11] = '{I,O,8'h04,32'h0, O,O,O,8'h00,32'h0,
              O,O,I,O,8'h04,I,O,32'h1234_5678};
    v[12] = '{O,O,8'h00,32'h0, I,O,I,8'h08,32'h0,
              O,I,I,O,8'h08,I,O,32'h2222_2222};
    v[13] = '{I,O,8'h00,32'h0, O,O,I,8'h00,32'h0,
              I,O,O,O,8'h00,O,I,32'h3333_3333};
    v[14] = '{I,O,8'h00,32'h0, O,O,O,8'h00,32'h0,
              I,O,O,O,8'h00,O,O,32'h0};
    v[15] = '{I,O,8'h00,32'h0, O,O,O,8'h00,32'h0,
              O,O,I,O,8'h00,O,O,32'h0};
    v[16] = '{O,O,8'h00,32'h0, O,O,O,8'h00,32'h0,
              O,O,O,O,8'h00,I,O,32'h1111_1111};
    idle = v[0];

    // Reset with both requesters active.
    x = '{I,O,8'h40,32'h0, I,O,O,8'h80,32'h0,
          I,O,O,O,8'h00,O,O,32'h0};
    drive(x);
    @(negedge clk);
    check(x, "reset");
    cycle();
    drive(idle);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(v[i]);
      @(negedge clk);
      check(v[i], $sformatf("row%0d", i));
      cycle();
    end

    // Reset arrives right after a granted CPU read.
    drive(v[1]);
    @(negedge clk);
    check(v[1], "pre_rst_rd");
    cycle();
    rst_n = 1'b0;
    x = '{I,O,8'h40,32'h0, I,O,O,8'h80,32'h0,
          I,O,O,O,8'h00,O,O,32'h0};
    drive(x);
    @(negedge clk);
    check(x, "mid_rst");
    cycle();
    rst_n = 1'b1;
    drive(idle);
    @(negedge clk);
    check(idle, "post_rst");
    cycle();

    // Sustained contention.
`ifdef DMEM_ARB_STARVE_EN
    ncont = 8;
`else
    ncont = 20;
`endif
    prev_c = 1'b0;
    prev_l = 1'b0;
    for (int k = 0; k < ncont; k++) begin
      lw = ldr_wins(k);
      x = '{I,O,8'h40,32'h0, I,O,O,8'h80,32'h0,
            lw, lw, I, O, (lw ? 8'h80 : 8'h40),
            prev_c, prev_l,
            (prev_l ? 32'hCAFE_F00D : 32'h1234_5678)};
      drive(x);
      @(negedge clk);
      check(x, $sformatf("cont%0d", k));
      cycle();
      prev_c = ~lw;
      prev_l = lw;
    end
    drive(idle);
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
